// File: rtl/blink_pkg.sv
// Shared constants and types for the blinker speed control: step table,
// index limits and the auto-repeat state encoding.
package blink_pkg;

  localparam int IDX_MAX        = 6;
  localparam int STEP_W         = 7;
  localparam int IDX_W          = 3;
  localparam int BLINK_TERMINAL = 50_000_000;

  localparam logic [STEP_W-1:0] STEP_TABLE [0:IDX_MAX] = '{
    7'd1, 7'd2, 7'd5, 7'd10, 7'd20, 7'd50, 7'd100
  };

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEATING = 2'd2
  } rep_state_t;

  // Step lookup; an out-of-range index clamps to the fastest step.
  function automatic logic [STEP_W-1:0] step_of(input logic [IDX_W-1:0] idx);
    if (idx > IDX_W'(IDX_MAX)) return STEP_TABLE[IDX_MAX];
    return STEP_TABLE[idx];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button front end: 2-FF synchronizer, stable-level debounce and a
// single-cycle pulse on the debounced press (1->0) transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          level_d;

  // Two-stage synchronizer; idles at released (1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive mismatching samples; the sample that would make the
  // count reach DEBOUNCE_CYCLES flips the accepted level instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_p1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Edge detect on the debounced level: pulse only on press, never on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/speed_keypad.sv
// Up/down speed control for the LED blinker: two debounced keys drive a
// saturating index 0..6 with hold-to-repeat, and the registered outputs give
// the per-clock increment the blinker adds toward its terminal count.
module speed_keypad
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              KEY_UP,
  input  logic              KEY_DN,
  output logic [STEP_W-1:0] step,
  output logic [IDX_W-1:0]  index,
  output logic              changed,
  output logic              at_min,
  output logic              at_max
);

  localparam int            TMAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int            TW      = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] REP_LD  = TW'(REPEAT_CYCLES);

  // Saturating index move; simultaneous up and down cancel.
  function automatic logic [IDX_W-1:0] next_index(
    input logic [IDX_W-1:0] idx,
    input logic             inc,
    input logic             dec
  );
    if (inc && !dec && idx < IDX_W'(IDX_MAX)) return idx + 1'b1;
    if (dec && !inc && idx > '0)              return idx - 1'b1;
    return idx;
  endfunction

  logic level_up, press_up;
  logic level_dn, press_dn;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .key_raw (KEY_UP),
    .level   (level_up),
    .press   (press_up)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dn (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .key_raw (KEY_DN),
    .level   (level_dn),
    .press   (press_dn)
  );

  rep_state_t     state, state_nxt;
  logic           dir_up;
  logic [TW-1:0]  timer;
  logic           single_up, single_dn;
  logic           rep_exit, expire;
  logic           rep_step, load_hold;
  logic           inc, dec;
  logic [IDX_W-1:0] idx_nxt;

  assign single_up = press_up & ~press_dn;
  assign single_dn = press_dn & ~press_up;
  assign expire    = (timer == '0);
  // Leave repeat as soon as the latched key is released or the other key goes down.
  assign rep_exit  = (state != IDLE) &&
                     (dir_up ? (level_up || !level_dn) : (level_dn || !level_up));

  // Repeat FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Repeat FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (single_up || single_dn) state_nxt = WAIT_HOLD;
      WAIT_HOLD: if (rep_exit)               state_nxt = IDLE;
                 else if (expire)            state_nxt = REPEATING;
      REPEATING: if (rep_exit)               state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Repeat FSM outputs: step request and timer load strobes.
  always_comb begin
    rep_step  = 1'b0;
    load_hold = 1'b0;
    case (state)
      IDLE:      load_hold = single_up || single_dn;
      WAIT_HOLD,
      REPEATING: rep_step  = !rep_exit && expire;
      default:   ;
    endcase
  end

  // Hold/repeat timer and latched direction.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      timer  <= '0;
      dir_up <= 1'b0;
    end else if (load_hold) begin
      timer  <= HOLD_LD;
      dir_up <= single_up;
    end else if (rep_step) begin
      timer  <= REP_LD;
    end else if (state_nxt == IDLE) begin
      timer  <= '0;
    end else if (!expire) begin
      timer  <= timer - 1'b1;
    end
  end

  assign inc     = single_up || (rep_step &&  dir_up);
  assign dec     = single_dn || (rep_step && !dir_up);
  assign idx_nxt = next_index(index, inc, dec);

  // Index register with step decoded from the next index so both move together.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      index   <= '0;
      step    <= STEP_TABLE[0];
      changed <= 1'b0;
      at_min  <= 1'b1;
      at_max  <= 1'b0;
    end else begin
      index   <= idx_nxt;
      step    <= step_of(idx_nxt);
      changed <= (idx_nxt != index);
      at_min  <= (idx_nxt == '0);
      at_max  <= (idx_nxt == IDX_W'(IDX_MAX));
    end
  end

endmodule

// File: tb/tb_speed_keypad.sv
// Directed bench for speed_keypad with short debounce/hold/repeat times.
module tb_speed_keypad;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       KEY_UP;
  logic       KEY_DN;
  logic [6:0] step;
  logic [2:0] index;
  logic       changed;
  logic       at_min;
  logic       at_max;

  int cyc_n    = 0;
  int n_chg    = 0;
  int pass_cnt = 0;
  int total    = 0;

  logic [6:0] exp_step [0:6] = '{7'd1, 7'd2, 7'd5, 7'd10, 7'd20, 7'd50, 7'd100};

  speed_keypad #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .KEY_UP   (KEY_UP),
    .KEY_DN   (KEY_DN),
    .step     (step),
    .index    (index),
    .changed  (changed),
    .at_min   (at_min),
    .at_max   (at_max)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total);
    $fatal(1);
  end

  // Advance one clock; sample on the falling edge and tally changed pulses.
  task automatic cyc();
    @(negedge CLOCK_50);
    cyc_n++;
    if (changed === 1'b1) n_chg++;
  endtask

  task automatic test_reset();
    int base;
    RESET_N = 1'b0; KEY_UP = 1'b1; KEY_DN = 1'b1;
    repeat (3) cyc();
    RESET_N = 1'b1;
    cyc();
    total++; if (index !== 3'd0) $display("FAIL reset_index: got %0d want 0", index); else pass_cnt++;
    total++; if (step !== 7'd1) $display("FAIL reset_step: got %0d want 1", step); else pass_cnt++;
    total++; if (at_min !== 1'b1) $display("FAIL reset_at_min: got %b want 1", at_min); else pass_cnt++;
    total++; if (at_max !== 1'b0) $display("FAIL reset_at_max: got %b want 0", at_max); else pass_cnt++;
    total++; if (changed !== 1'b0) $display("FAIL reset_changed: got %b want 0", changed); else pass_cnt++;
    base = n_chg;
    repeat (50) cyc();
    total++; if (n_chg - base != 0) $display("FAIL reset_idle_changes: got %0d want 0", n_chg - base); else pass_cnt++;
    total++; if (index !== 3'd0) $display("FAIL reset_idle_index: got %0d want 0", index); else pass_cnt++;
  endtask

  task automatic test_bounce();
    int base;
    base = n_chg;
    for (int i = 0; i < 30; i++) begin
      KEY_UP = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    KEY_UP = 1'b0;
    repeat (7) cyc();
    total++; if (index !== 3'd0) $display("FAIL bounce_early_index: got %0d want 0", index); else pass_cnt++;
    total++; if (n_chg - base != 0) $display("FAIL bounce_glitch_changes: got %0d want 0", n_chg - base); else pass_cnt++;
    cyc();
    total++; if (index !== 3'd1) $display("FAIL bounce_index: got %0d want 1", index); else pass_cnt++;
    total++; if (step !== 7'd2) $display("FAIL bounce_step: got %0d want 2", step); else pass_cnt++;
    total++; if (changed !== 1'b1) $display("FAIL bounce_changed: got %b want 1", changed); else pass_cnt++;
    KEY_UP = 1'b1;
    repeat (40) cyc();
    total++; if (n_chg - base != 1) $display("FAIL bounce_total_changes: got %0d want 1", n_chg - base); else pass_cnt++;
    total++; if (index !== 3'd1) $display("FAIL bounce_after_release: got %0d want 1", index); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int base;
    int want;
    RESET_N = 1'b0; cyc(); RESET_N = 1'b1; cyc();
    for (int k = 1; k <= 7; k++) begin
      base = n_chg;
      want = (k > 6) ? 6 : k;
      KEY_UP = 1'b0; repeat (8) cyc();
      total++; if (index !== 3'(want)) $display("FAIL sat_up_index_%0d: got %0d want %0d", k, index, want); else pass_cnt++;
      total++; if (step !== exp_step[want]) $display("FAIL sat_up_step_%0d: got %0d want %0d", k, step, exp_step[want]); else pass_cnt++;
      KEY_UP = 1'b1; repeat (12) cyc();
      total++; if (n_chg - base != ((k <= 6) ? 1 : 0)) $display("FAIL sat_up_changes_%0d: got %0d want %0d", k, n_chg - base, (k <= 6) ? 1 : 0); else pass_cnt++;
    end
    total++; if (at_max !== 1'b1) $display("FAIL sat_at_max: got %b want 1", at_max); else pass_cnt++;
    for (int k = 1; k <= 7; k++) begin
      base = n_chg;
      want = (6 - k < 0) ? 0 : 6 - k;
      KEY_DN = 1'b0; repeat (8) cyc();
      total++; if (index !== 3'(want)) $display("FAIL sat_dn_index_%0d: got %0d want %0d", k, index, want); else pass_cnt++;
      KEY_DN = 1'b1; repeat (12) cyc();
      total++; if (n_chg - base != ((k <= 6) ? 1 : 0)) $display("FAIL sat_dn_changes_%0d: got %0d want %0d", k, n_chg - base, (k <= 6) ? 1 : 0); else pass_cnt++;
    end
    total++; if (step !== 7'd1) $display("FAIL sat_min_step: got %0d want 1", step); else pass_cnt++;
    total++; if (at_min !== 1'b1) $display("FAIL sat_at_min: got %b want 1", at_min); else pass_cnt++;
  endtask

  task automatic test_autorepeat();
    int stamps[$];
    int exp_t [0:3] = '{8, 29, 38, 47};
    int t0, got, base;
    KEY_UP = 1'b0;
    t0 = cyc_n;
    for (int i = 0; i < 120 && stamps.size() < 4; i++) begin
      cyc();
      if (changed === 1'b1) stamps.push_back(cyc_n - t0);
    end
    KEY_UP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = (i < stamps.size()) ? stamps[i] : -1;
      total++; if (got != exp_t[i]) $display("FAIL repeat_time_%0d: got %0d want %0d", i, got, exp_t[i]); else pass_cnt++;
    end
    total++; if (index !== 3'd4) $display("FAIL repeat_index: got %0d want 4", index); else pass_cnt++;
    base = n_chg;
    repeat (40) cyc();
    total++; if (n_chg - base != 0) $display("FAIL repeat_after_release: got %0d want 0", n_chg - base); else pass_cnt++;
    total++; if (index !== 3'd4) $display("FAIL repeat_final_index: got %0d want 4", index); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int base;
    base = n_chg;
    KEY_UP = 1'b0; KEY_DN = 1'b0;
    repeat (40) cyc();
    total++; if (n_chg - base != 0) $display("FAIL simul_changes: got %0d want 0", n_chg - base); else pass_cnt++;
    total++; if (index !== 3'd4) $display("FAIL simul_index: got %0d want 4", index); else pass_cnt++;
    KEY_DN = 1'b1;
    repeat (30) cyc();
    total++; if (n_chg - base != 0) $display("FAIL simul_release_dn: got %0d want 0", n_chg - base); else pass_cnt++;
    total++; if (index !== 3'd4) $display("FAIL simul_release_index: got %0d want 4", index); else pass_cnt++;
    KEY_UP = 1'b1;
    repeat (10) cyc();
  endtask

  task automatic test_reset_mid_repeat();
    int t0;
    RESET_N = 1'b0; cyc(); RESET_N = 1'b1; cyc();
    KEY_UP = 1'b0;
    t0 = cyc_n;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (index === 3'd3) break;
    end
    total++; if (cyc_n - t0 != 38) $display("FAIL midrep_reach3: got %0d cycles want 38", cyc_n - t0); else pass_cnt++;
    cyc();
    RESET_N = 1'b0;
    cyc();
    total++; if (index !== 3'd0) $display("FAIL midrep_reset_index: got %0d want 0", index); else pass_cnt++;
    total++; if (step !== 7'd1) $display("FAIL midrep_reset_step: got %0d want 1", step); else pass_cnt++;
    total++; if (at_min !== 1'b1) $display("FAIL midrep_reset_at_min: got %b want 1", at_min); else pass_cnt++;
    RESET_N = 1'b1;
    repeat (7) cyc();
    total++; if (index !== 3'd0) $display("FAIL midrep_early_index: got %0d want 0", index); else pass_cnt++;
    cyc();
    total++; if (index !== 3'd1) $display("FAIL midrep_press_index: got %0d want 1", index); else pass_cnt++;
    total++; if (changed !== 1'b1) $display("FAIL midrep_press_changed: got %b want 1", changed); else pass_cnt++;
    repeat (21) cyc();
    total++; if (index !== 3'd2) $display("FAIL midrep_repeat_index: got %0d want 2", index); else pass_cnt++;
    total++; if (changed !== 1'b1) $display("FAIL midrep_repeat_changed: got %b want 1", changed); else pass_cnt++;
    KEY_UP = 1'b1;
    repeat (30) cyc();
    total++; if (index !== 3'd2) $display("FAIL midrep_final_index: got %0d want 2", index); else pass_cnt++;
  endtask

  initial begin
    RESET_N = 1'b0;
    KEY_UP  = 1'b1;
    KEY_DN  = 1'b1;
    test_reset();
    test_bounce();
    test_saturation();
    test_autorepeat();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
